// File: rtl/sobel_conv_ctrl_pkg.sv
// Shared types and widths for the Sobel convolution controller slice.
package sobel_pkg;

  localparam int PIX_W         = 4;
  localparam int COEF_W        = 5;
  localparam int ACC_W_DEFAULT = 12;

  typedef enum bit [2:0] {
    ST_IDLE,
    ST_X_START,
    ST_X_RUN,
    ST_Y_START,
    ST_Y_RUN,
    ST_OUTPUT
  } ctrl_state_t;

endpackage

// File: rtl/sobel_conv_ctrl_if.sv
// Window-in / select-unit / result-out signal bundle around the Sobel controller.
interface sobel_conv_ctrl_if import sobel_pkg::*; #(
  parameter int ACC_W = ACC_W_DEFAULT
);

  logic                             win_valid;
  logic                             win_ready;
  logic [2:0][2:0][PIX_W-1:0]       pixels;
  logic [2:0][2:0][PIX_W-1:0]       pix_q;
  logic                             x_calc_enable;
  logic                             y_calc_enable;
  logic signed [COEF_W-1:0]         x_a;
  logic signed [COEF_W-1:0]         y_a;
  logic [COEF_W-1:0]                x_b;
  logic [COEF_W-1:0]                y_b;
  logic                             x_done;
  logic                             y_done;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [ACC_W-1:0]          gx;
  logic signed [ACC_W-1:0]          gy;
  logic [ACC_W-1:0]                 mag;
  // "edge" is a reserved word, hence edge_flag.
  logic                             edge_flag;
  logic                             err;

  modport master (
    input  win_valid, pixels, x_a, x_b, y_a, y_b, x_done, y_done, out_ready,
    output win_ready, pix_q, x_calc_enable, y_calc_enable, out_valid,
           gx, gy, mag, edge_flag, err
  );

  modport slave (
    output win_valid, pixels, x_a, x_b, y_a, y_b, x_done, y_done, out_ready,
    input  win_ready, pix_q, x_calc_enable, y_calc_enable, out_valid,
           gx, gy, mag, edge_flag, err
  );

endinterface

// File: rtl/sobel_conv_ctrl_mac.sv
// Shared signed COEF_W x COEF_W multiply-accumulate; clear has priority over en.
module sobel_mac import sobel_pkg::*; #(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = 2 * COEF_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  assign prod     = PW'(a) * PW'(b);
  assign prod_ext = ACC_W'(prod);

  // Wrapping accumulate; the worst-case window sum fits ACC_W=12.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/sobel_conv_ctrl.sv
// Sequences one 3x3 window through the X then Y select units over a single
// shared MAC and publishes gx, gy, |gx|+|gy| and an edge flag.
module sobel_conv_ctrl import sobel_pkg::*; #(
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int TIMEOUT = 15,
  parameter int THRESH  = 128
) (
  input logic               clk,
  input logic               n_rst,
  sobel_conv_ctrl_if.master bus
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ACC_W-1:0] THRESH_U = ACC_W'(THRESH);

  function automatic logic [ACC_W-1:0] abs_val(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  ctrl_state_t                state_q;
  logic [2:0][2:0][PIX_W-1:0] win_q;
  logic                       rdy_q, xen_q, yen_q, vld_q, edge_q, err_q;
  logic signed [ACC_W-1:0]    gx_q, gy_q;
  logic [ACC_W-1:0]           mag_q;
  logic [CNT_W-1:0]           cnt_q;

  logic                       mac_clr, mac_en;
  logic signed [COEF_W-1:0]   mac_a, mac_b;
  logic signed [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]           mag_d;
  logic                       timeout;

  assign mac_en  = (state_q == ST_X_RUN) || (state_q == ST_Y_RUN);
  assign mac_clr = ((state_q == ST_IDLE)  && bus.win_valid) ||
                   ((state_q == ST_X_RUN) && bus.x_done)    ||
                   ((state_q == ST_Y_RUN) && bus.y_done);
  assign mac_a   = (state_q == ST_Y_RUN) ? bus.y_a : bus.x_a;
  assign mac_b   = (state_q == ST_Y_RUN) ? bus.y_b : bus.x_b;
  // gy is still in the accumulator on the cycle that enters OUTPUT.
  assign mag_d   = abs_val(gx_q) + abs_val(acc);
  assign timeout = (cnt_q == CNT_LAST);

  sobel_mac #(.ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      rdy_q   <= 1'b1;
      xen_q   <= 1'b0;
      yen_q   <= 1'b0;
      vld_q   <= 1'b0;
      edge_q  <= 1'b0;
      err_q   <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      xen_q <= 1'b0;
      yen_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.win_valid) begin
            win_q   <= bus.pixels;
            rdy_q   <= 1'b0;
            xen_q   <= 1'b1;
            state_q <= ST_X_START;
          end
        end
        ST_X_START: begin
          cnt_q   <= '0;
          state_q <= ST_X_RUN;
        end
        ST_X_RUN: begin
          // done takes priority over a simultaneous timeout
          if (bus.x_done) begin
            gx_q    <= acc;
            yen_q   <= 1'b1;
            state_q <= ST_Y_START;
          end else if (timeout) begin
            err_q   <= 1'b1;
            gx_q    <= '0;
            gy_q    <= '0;
            mag_q   <= '0;
            edge_q  <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= ST_OUTPUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_Y_START: begin
          cnt_q   <= '0;
          state_q <= ST_Y_RUN;
        end
        ST_Y_RUN: begin
          if (bus.y_done) begin
            gy_q    <= acc;
            mag_q   <= mag_d;
            edge_q  <= (mag_d >= THRESH_U);
            vld_q   <= 1'b1;
            state_q <= ST_OUTPUT;
          end else if (timeout) begin
            err_q   <= 1'b1;
            gx_q    <= '0;
            gy_q    <= '0;
            mag_q   <= '0;
            edge_q  <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= ST_OUTPUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.win_ready     = rdy_q;
  assign bus.pix_q         = win_q;
  assign bus.x_calc_enable = xen_q;
  assign bus.y_calc_enable = yen_q;
  assign bus.out_valid     = vld_q;
  assign bus.gx            = gx_q;
  assign bus.gy            = gy_q;
  assign bus.mag           = mag_q;
  assign bus.edge_flag     = edge_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_sobel_conv_ctrl.sv
// Directed bench for sobel_conv_ctrl with cycle-stepped stub X/Y select units.
module tb_sobel_conv_ctrl;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sobel_conv_ctrl_if #(.ACC_W(12)) bus ();

  sobel_conv_ctrl #(.ACC_W(12), .TIMEOUT(15), .THRESH(128)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [4:0] xa_t [6];
  logic signed [4:0] ya_t [6];
  logic [4:0]        xb_t [6];
  logic [4:0]        yb_t [6];
  bit                x_hang = 1'b0;

  int xe, ye, ov, xpulses, ypulses;
  logic rdy0;
  logic signed [11:0] mid_gx;
  logic [2:0][2:0][3:0] pixq_c1;
  logic [2:0][2:0][3:0] pa, pb;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_stubs();
    bus.x_a = '0; bus.x_b = '0; bus.x_done = 1'b0;
    bus.y_a = '0; bus.y_b = '0; bus.y_done = 1'b0;
  endtask

  task automatic fill(input bit is_y, input int a1, input int b1, input int n1,
                      input int a2, input int b2);
    for (int i = 0; i < 6; i++) begin
      if (is_y) begin
        ya_t[i] = (i < n1) ? 5'(a1) : 5'(a2);
        yb_t[i] = (i < n1) ? 5'(b1) : 5'(b2);
      end else begin
        xa_t[i] = (i < n1) ? 5'(a1) : 5'(a2);
        xb_t[i] = (i < n1) ? 5'(b1) : 5'(b2);
      end
    end
  endtask

  // Cycle 0 is the handshake cycle; stubs answer an enable with 6 operand
  // pairs on the following cycles, then done with zero operands.
  task automatic drive_window(input logic [2:0][2:0][3:0] pix, input int abort_at);
    int xs, ys;
    xs = -1; ys = -1; xe = -1; ye = -1; ov = -1; xpulses = 0; ypulses = 0;
    for (int c = 0; c <= 40; c++) begin
      step();
      zero_stubs();
      if (c == 0) begin
        bus.win_valid = 1'b1;
        bus.pixels    = pix;
        bus.out_ready = 1'b0;
      end else begin
        bus.win_valid = 1'b0;
      end
      if (xs >= 0 && c >= xs && c - xs < 6) begin
        bus.x_a = xa_t[c-xs]; bus.x_b = xb_t[c-xs];
      end else if (xs >= 0 && c - xs == 6 && !x_hang) begin
        bus.x_done = 1'b1;
      end
      if (ys >= 0 && c >= ys && c - ys < 6) begin
        bus.y_a = ya_t[c-ys]; bus.y_b = yb_t[c-ys];
      end else if (ys >= 0 && c - ys == 6) begin
        bus.y_done = 1'b1;
      end
      @(negedge clk);
      if (c == 0) rdy0 = bus.win_ready;
      if (c == 1) pixq_c1 = bus.pix_q;
      if (bus.x_calc_enable === 1'b1) begin
        xpulses++;
        if (xe < 0) begin xe = c; xs = c + 1; end
      end
      if (bus.y_calc_enable === 1'b1) begin
        ypulses++;
        if (ye < 0) begin ye = c; ys = c + 1; end
      end
      if (bus.out_valid === 1'b1) begin
        ov = c;
        break;
      end
      if (c == abort_at) begin
        mid_gx = bus.gx;
        n_rst  = 1'b0;
        #1;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.win_valid = 1'b0; bus.out_ready = 1'b0; bus.pixels = '0;
    zero_stubs();
    repeat (2) @(negedge clk);
    checks++; if (bus.win_ready !== 1'b1) begin errors++; $display("FAIL rst_win_ready: got %b want 1", bus.win_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if ({bus.x_calc_enable, bus.y_calc_enable} !== 2'b00) begin errors++; $display("FAIL rst_enables: got %b%b want 00", bus.x_calc_enable, bus.y_calc_enable); end
    checks++; if (bus.gx !== 12'sd0 || bus.gy !== 12'sd0) begin errors++; $display("FAIL rst_gx_gy: got %0d/%0d want 0/0", bus.gx, bus.gy); end
    checks++; if (bus.mag !== 12'd0) begin errors++; $display("FAIL rst_mag: got %0d want 0", bus.mag); end
    checks++; if ({bus.edge_flag, bus.err} !== 2'b00) begin errors++; $display("FAIL rst_edge_err: got %b%b want 00", bus.edge_flag, bus.err); end
    checks++; if (bus.pix_q !== 36'h0) begin errors++; $display("FAIL rst_pix_q: got %h want 0", bus.pix_q); end
    n_rst = 1'b1;
  endtask

  task automatic test_zero_window();
    fill(0, 0, 0, 6, 0, 0); fill(1, 0, 0, 6, 0, 0); x_hang = 1'b0;
    drive_window('0, -1);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL zero_ready_c0: got %b want 1", rdy0); end
    checks++; if (xe != 1 || xpulses != 1) begin errors++; $display("FAIL zero_x_enable: got cycle %0d pulses %0d want 1/1", xe, xpulses); end
    checks++; if (ye != 9 || ypulses != 1) begin errors++; $display("FAIL zero_y_enable: got cycle %0d pulses %0d want 9/1", ye, ypulses); end
    checks++; if (ov != 17) begin errors++; $display("FAIL zero_latency: got %0d want 17", ov); end
    checks++; if (bus.gx !== 12'sd0 || bus.gy !== 12'sd0 || bus.mag !== 12'd0) begin errors++; $display("FAIL zero_results: got %0d/%0d/%0d want 0/0/0", bus.gx, bus.gy, bus.mag); end
    checks++; if ({bus.edge_flag, bus.err} !== 2'b00) begin errors++; $display("FAIL zero_edge_err: got %b%b want 00", bus.edge_flag, bus.err); end
    accept();
    checks++; if (bus.out_valid !== 1'b0 || bus.win_ready !== 1'b1) begin errors++; $display("FAIL zero_release: got valid %b ready %b want 0 1", bus.out_valid, bus.win_ready); end
  endtask

  task automatic test_gx45();
    fill(0, 1, 15, 3, -1, 0); fill(1, 0, 0, 6, 0, 0);
    drive_window(pa, -1);
    checks++; if (pixq_c1 !== pa) begin errors++; $display("FAIL gx45_pix_q: got %h want %h", pixq_c1, pa); end
    checks++; if (ov != 17) begin errors++; $display("FAIL gx45_latency: got %0d want 17", ov); end
    checks++; if (bus.gx !== 12'sd45 || bus.gy !== 12'sd0) begin errors++; $display("FAIL gx45_gx_gy: got %0d/%0d want 45/0", bus.gx, bus.gy); end
    checks++; if (bus.mag !== 12'd45 || bus.edge_flag !== 1'b0) begin errors++; $display("FAIL gx45_mag_edge: got %0d/%b want 45/0", bus.mag, bus.edge_flag); end
    accept();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gx45_release: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_max();
    fill(0, -16, 15, 6, 0, 0); fill(1, -16, 15, 6, 0, 0);
    drive_window(pb, -1);
    checks++; if (bus.gx !== -12'sd1440 || bus.gy !== -12'sd1440) begin errors++; $display("FAIL max_gx_gy: got %0d/%0d want -1440/-1440", bus.gx, bus.gy); end
    checks++; if (bus.mag !== 12'd2880) begin errors++; $display("FAIL max_mag: got %0d want 2880", bus.mag); end
    checks++; if (bus.edge_flag !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL max_edge_err: got %b%b want 10", bus.edge_flag, bus.err); end
    accept();
  endtask

  task automatic test_back_to_back();
    fill(0, -16, 15, 6, 0, 0); fill(1, 2, 7, 6, 0, 0);
    drive_window(pa, -1);
    checks++; if (ov != 17 || bus.gy !== 12'sd84 || bus.mag !== 12'd1524) begin errors++; $display("FAIL hold_result: got ov %0d gy %0d mag %0d want 17 84 1524", ov, bus.gy, bus.mag); end
    bus.win_valid = 1'b1;
    bus.pixels    = pb;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.win_ready !== 1'b0) begin errors++; $display("FAIL hold_hs_%0d: got valid %b ready %b want 1 0", k, bus.out_valid, bus.win_ready); end
      checks++; if (bus.gx !== -12'sd1440 || bus.gy !== 12'sd84 || bus.mag !== 12'd1524 || bus.edge_flag !== 1'b1) begin
        errors++; $display("FAIL hold_data_%0d: got %0d/%0d/%0d/%b want -1440/84/1524/1", k, bus.gx, bus.gy, bus.mag, bus.edge_flag);
      end
    end
    bus.out_ready = 1'b1;
    fill(0, 1, 15, 3, -1, 0); fill(1, 0, 0, 6, 0, 0);
    drive_window(pb, -1);
    checks++; if (rdy0 !== 1'b1 || xe != 1) begin errors++; $display("FAIL b2b_accept: got ready %b x_en cycle %0d want 1 1", rdy0, xe); end
    checks++; if (pixq_c1 !== pb) begin errors++; $display("FAIL b2b_pix_q: got %h want %h", pixq_c1, pb); end
    checks++; if (ov != 17 || bus.gx !== 12'sd45 || bus.mag !== 12'd45) begin errors++; $display("FAIL b2b_result: got ov %0d gx %0d mag %0d want 17 45 45", ov, bus.gx, bus.mag); end
    accept();
  endtask

  task automatic test_timeout();
    fill(0, 1, 15, 6, 0, 0); fill(1, 0, 0, 6, 0, 0); x_hang = 1'b1;
    drive_window(pa, -1);
    x_hang = 1'b0;
    checks++; if (ov != 17) begin errors++; $display("FAIL to_latency: got %0d want 17", ov); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bus.err); end
    checks++; if (bus.gx !== 12'sd0 || bus.gy !== 12'sd0 || bus.mag !== 12'd0 || bus.edge_flag !== 1'b0) begin errors++; $display("FAIL to_zeroed: got %0d/%0d/%0d/%b want 0/0/0/0", bus.gx, bus.gy, bus.mag, bus.edge_flag); end
    checks++; if (ypulses != 0) begin errors++; $display("FAIL to_no_y_enable: got %0d pulses want 0", ypulses); end
    accept();
    checks++; if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL to_release: got err %b valid %b want 0 0", bus.err, bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    fill(0, 1, 15, 3, -1, 0); fill(1, 2, 7, 6, 0, 0);
    drive_window(pa, 12);
    checks++; if (mid_gx !== 12'sd45) begin errors++; $display("FAIL mid_gx_before_rst: got %0d want 45", mid_gx); end
    checks++; if (bus.win_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: got ready %b valid %b want 1 0", bus.win_ready, bus.out_valid); end
    checks++; if (bus.gx !== 12'sd0 || bus.gy !== 12'sd0 || bus.mag !== 12'd0) begin errors++; $display("FAIL mid_rst_data: got %0d/%0d/%0d want 0/0/0", bus.gx, bus.gy, bus.mag); end
    checks++; if (bus.pix_q !== 36'h0 || bus.y_calc_enable !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL mid_rst_misc: got pix %h yen %b err %b want 0 0 0", bus.pix_q, bus.y_calc_enable, bus.err); end
    zero_stubs();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid: got %b want 0", bus.out_valid); end
    fill(0, 2, 3, 6, 0, 0); fill(1, 0, 0, 6, 0, 0);
    drive_window(pb, -1);
    checks++; if (ov != 17 || bus.gx !== 12'sd36 || bus.gy !== 12'sd0 || bus.mag !== 12'd36) begin errors++; $display("FAIL mid_next_window: got ov %0d gx %0d gy %0d mag %0d want 17 36 0 36", ov, bus.gx, bus.gy, bus.mag); end
    accept();
  endtask

  initial begin
    pa = 36'h123456789;
    pb = 36'hFEDCBA987;
    test_reset();
    test_zero_window();
    test_gx45();
    test_max();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sobel_conv_ctrl.md
Name: sobel_conv_ctrl

Overview:
- Sequences one Sobel pixel window through the X and Y bit-select units.
- Owns the single signed multiply-accumulate datapath that both units share: muxes each unit's a/b operand stream into it, then publishes gx, gy, magnitude and an edge flag.
- Sits between the window buffer (upstream valid/ready) and the edge-output stage (downstream valid/ready).
- Processes one window at a time; no overlap between windows.

Parameters:
- ACC_W, 12, accumulator/result width in bits; signed, two's complement.
- TIMEOUT, 15, maximum cycles in one RUN phase before the phase is aborted.
- THRESH, 128, unsigned magnitude threshold for edge.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- win_valid  in  1  upstream window available
- win_ready  out  1  controller accepts a window (IDLE only)
- pixels  in  [2:0][2:0][3:0]  3x3 window of unsigned 4-bit pixels
- pix_q  out  [2:0][2:0][3:0]  latched window, fed to both select units
- x_calc_enable  out  1  one-cycle start pulse to the X select unit
- y_calc_enable  out  1  one-cycle start pulse to the Y select unit
- x_a, y_a  in  5  signed filter operand from the respective unit
- x_b, y_b  in  5  zero-extended pixel operand from the respective unit
- x_done, y_done  in  1  calc_done from the respective unit
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- gx, gy  out  ACC_W  signed gradients
- mag  out  ACC_W  unsigned |gx|+|gy|
- edge  out  1  mag >= THRESH
- err  out  1  phase timeout occurred; result forced to zero

Behaviour:
- Reset state:
  - FSM goes to IDLE.
  - win_ready=1. All other outputs are 0: pix_q, enables, out_valid, gx, gy, mag, edge, err.
  - Accumulator and timeout counter are cleared.
- State set (states are listed in order): IDLE, X_START, X_RUN, Y_START, Y_RUN, OUTPUT.
- IDLE:
  - win_ready=1.
  - On win_valid: latch pix_q from pixels, clear the accumulator, go to X_START.
- X_START:
  - x_calc_enable=1 for exactly one cycle.
  - Clear the timeout counter; go to X_RUN.
- X_RUN: each cycle, acc <= acc + x_a*x_b.
  - Product is a signed 5x5 multiply giving 10 bits, sign-extended to ACC_W.
  - Idle zero operands contribute nothing.
  - On x_done: copy acc to the gx register, clear acc, go to Y_START.
  - Otherwise, if the counter reaches TIMEOUT-1: set err, go to OUTPUT.
- Y_START and Y_RUN mirror X_START and X_RUN using the y_* signals; on y_done, acc goes to the gy register.
- Entry to OUTPUT:
  - Register mag = |gx| + |gy| and edge.
  - If err is set: gx=gy=mag=0 and edge=0.
- OUTPUT:
  - out_valid=1; all result outputs are held stable.
  - On out_ready: clear out_valid and err, go to IDLE.
  - out_ready may arrive in the first OUTPUT cycle.
- Latency: handshake at cycle 0.
  - x_calc_enable at cycle 1; X_RUN accumulates cycles 2..8, with x_done expected at cycle 8.
  - y_calc_enable at cycle 9; Y_RUN accumulates cycles 10..16.
  - out_valid at cycle 17; window-to-window throughput is 18 cycles minimum.
- Arithmetic:
  - Accumulation wraps (no saturation); 12 bits covers ±1440 worst case.
  - |x| of the most negative ACC_W value is not reachable with ACC_W >= 12.
- Simultaneous events:
  - x_done arriving in the cycle the timeout would fire: done wins.
  - win_valid outside IDLE is ignored, since win_ready=0.
- Reset mid-operation: immediate return to IDLE. Any partial result is discarded and no out_valid is produced.

Decomposition:
- Package sobel_pkg holds:
  - ctrl_state_t enum (typed enum bit [2:0]);
  - PIX_W=4 and COEF_W=5;
  - the default ACC_W.
- Sub-module sobel_mac:
  - Signed COEF_W x COEF_W multiply with accumulate.
  - Inputs: clear, en, a, b. Output: acc.
- The controller instantiates one sobel_mac and muxes x_a/x_b or y_a/y_b into it according to state.

Test Plan:
- All-zero window, stub units returning (0,0) x6 with done at the expected cycle -> out_valid at cycle 17; gx=gy=mag=0, edge=0, err=0.
- Stub X pairs (1,15)x3 and (-1,0)x3; Y pairs all (0,0) -> gx=45, gy=0, mag=45, edge=0.
- X pairs (-16,15)x6 and Y pairs (-16,15)x6 -> gx=gy=-1440, mag=2880, edge=1 (no wrap at ACC_W=12).
- out_ready held low for 5 cycles in OUTPUT -> gx/gy/mag/edge/out_valid stable; win_ready=0 despite win_valid=1. The next window is accepted only on the cycle after out_ready.
- Stub X unit never asserts x_done -> after 15 X_RUN cycles go to OUTPUT with err=1 and gx=gy=mag=0; y_calc_enable is never pulsed.
- n_rst asserted during Y_RUN -> all outputs zero and win_ready=1 immediately. A following window completes normally, with no carry-over of the old gx.
